// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - rv32i pipeline hazard controller
// Stage enables/flushes, EX forwarding selects, memory-wait freeze and perf counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rs1_addr,
   input  logic [4:0]       ex_rs2_addr,
   input  logic [4:0]       ex_rd,
   input  logic             ex_load_regfile,
   input  logic             ex_mem_read,
   input  logic [4:0]       mem_rd,
   input  logic             mem_load_regfile,
   input  logic [4:0]       wb_rd,
   input  logic             wb_load_regfile,
   input  logic             br_taken,
   input  logic             imem_req,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   input  logic             perf_clr,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd1_sel,
   output logic [1:0]       fwd2_sel,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] bubble_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t state, state_nx;
   logic   i_done, d_done;
   logic   i_ok, d_ok, advance;
   logic   load_use, redirect_ev, bubble_ev;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] m_rd, input logic m_ld,
                                          input logic [4:0] w_rd, input logic w_ld);
      if (src != 5'd0 && m_ld && m_rd == src)      return 2'b01;
      else if (src != 5'd0 && w_ld && w_rd == src) return 2'b10;
      else                                         return 2'b00;
   endfunction

   assign i_ok    = !imem_req | imem_resp | i_done;
   assign d_ok    = !dmem_req | dmem_resp | d_done;
   assign advance = i_ok & d_ok;

   assign load_use = ex_mem_read & ex_load_regfile & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1_addr == ex_rd)) |
                      (id_uses_rs2 & (id_rs2_addr == ex_rd)));

   // A redirect squashes the ID instruction, so it masks any load-use bubble.
   assign redirect_ev = advance & br_taken;
   assign bubble_ev   = advance & !br_taken & load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      case (state)
         RUN:     if (!advance) state_nx = WAIT;
         WAIT:    if (advance)  state_nx = RUN;
         default: state_nx = RUN;
      endcase
      if (rst_n && advance) begin
         pc_load     = 1'b1;
         if_id_load  = 1'b1;
         id_ex_load  = 1'b1;
         ex_mem_load = 1'b1;
         mem_wb_load = 1'b1;
         if (br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

   assign fwd1_sel = rst_n ? fwd_sel(ex_rs1_addr, mem_rd, mem_load_regfile, wb_rd, wb_load_regfile) : 2'b00;
   assign fwd2_sel = rst_n ? fwd_sel(ex_rs2_addr, mem_rd, mem_load_regfile, wb_rd, wb_load_regfile) : 2'b00;

   // Responses only latch while frozen; a same-cycle response in RUN is consumed directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_done <= 1'b0;
         d_done <= 1'b0;
      end else if (advance) begin
         i_done <= 1'b0;
         d_done <= 1'b0;
      end else if (state == WAIT) begin
         if (imem_resp) i_done <= 1'b1;
         if (dmem_resp) d_done <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count  <= '0;
         bubble_count <= '0;
         flush_count  <= '0;
      end else if (perf_clr) begin
         stall_count  <= '0;
         bubble_count <= '0;
         flush_count  <= '0;
      end else begin
         if (!advance && stall_count != '1)     stall_count  <= stall_count + CNT_ONE;
         if (bubble_ev && bubble_count != '1)   bubble_count <= bubble_count + CNT_ONE;
         if (redirect_ev && flush_count != '1)  flush_count  <= flush_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
// Random and directed stimulus checked against a reference model of the controller rules.
module tb_hazard_ctrl;

   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd, mem_rd, wb_rd;
   logic          id_uses_rs1, id_uses_rs2, ex_load_regfile, ex_mem_read;
   logic          mem_load_regfile, wb_load_regfile, br_taken;
   logic          imem_req, imem_resp, dmem_req, dmem_resp, perf_clr;
   logic          pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic          if_id_flush, id_ex_flush;
   logic [1:0]    fwd1_sel, fwd2_sel;
   logic [CW-1:0] stall_count, bubble_count, flush_count;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
      .ex_rd(ex_rd), .ex_load_regfile(ex_load_regfile), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_load_regfile(mem_load_regfile),
      .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile),
      .br_taken(br_taken), .imem_req(imem_req), .imem_resp(imem_resp),
      .dmem_req(dmem_req), .dmem_resp(dmem_resp), .perf_clr(perf_clr),
      .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
      .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
      .stall_count(stall_count), .bubble_count(bubble_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] en;    // {pc, if_id, id_ex, ex_mem, mem_wb}
      logic [1:0] fl;    // {if_id, id_ex}
      logic [1:0] f1;
      logic [1:0] f2;
      int         sc, bc, fc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Model state: whether each memory side is still owed a response, counters.
   bit   m_frozen, m_i_got, m_d_got;
   int   m_sc, m_bc, m_fc;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] a);
      if (a == 0) return 2'd0;
      if (mem_load_regfile && mem_rd == a) return 2'd1;
      if (wb_load_regfile && wb_rd == a) return 2'd2;
      return 2'd0;
   endfunction

   function automatic bit m_adv();
      bit i_sat = !imem_req || imem_resp || m_i_got;
      bit d_sat = !dmem_req || dmem_resp || m_d_got;
      return i_sat && d_sat;
   endfunction

   function automatic bit m_hazard();
      bit dep1 = id_uses_rs1 && id_rs1_addr == ex_rd;
      bit dep2 = id_uses_rs2 && id_rs2_addr == ex_rd;
      return ex_mem_read && ex_load_regfile && ex_rd != 0 && (dep1 || dep2);
   endfunction

   function automatic exp_t m_expect();
      exp_t e;
      e.f1 = m_fwd(ex_rs1_addr);
      e.f2 = m_fwd(ex_rs2_addr);
      e.sc = m_sc; e.bc = m_bc; e.fc = m_fc;
      if (!m_adv())          begin e.en = 5'b00000; e.fl = 2'b00; end
      else if (br_taken)     begin e.en = 5'b11111; e.fl = 2'b11; end
      else if (m_hazard())   begin e.en = 5'b00111; e.fl = 2'b01; end
      else                   begin e.en = 5'b11111; e.fl = 2'b00; end
      return e;
   endfunction

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic m_edge();
      bit adv = m_adv();
      if (perf_clr) begin
         m_sc = 0; m_bc = 0; m_fc = 0;
      end else begin
         if (!adv)                           m_sc = sat(m_sc);
         if (adv && br_taken)                m_fc = sat(m_fc);
         if (adv && !br_taken && m_hazard()) m_bc = sat(m_bc);
      end
      if (adv) begin
         m_i_got = 0; m_d_got = 0;
      end else if (m_frozen) begin
         m_i_got = m_i_got | imem_resp;
         m_d_got = m_d_got | dmem_resp;
      end
      m_frozen = !adv;
   endtask

   task automatic m_reset();
      m_frozen = 0; m_i_got = 0; m_d_got = 0;
      m_sc = 0; m_bc = 0; m_fc = 0;
   endtask

   task automatic idle_inputs();
      {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd, mem_rd, wb_rd} = '0;
      {id_uses_rs1, id_uses_rs2, ex_load_regfile, ex_mem_read} = '0;
      {mem_load_regfile, wb_load_regfile, br_taken} = '0;
      {imem_req, imem_resp, dmem_req, dmem_resp, perf_clr} = '0;
   endtask

   task automatic rand_inputs();
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_rs1_addr = 5'($urandom_range(0, 3));
      ex_rs2_addr = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      mem_rd      = 5'($urandom_range(0, 3));
      wb_rd       = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_load_regfile  = 1'($urandom_range(0, 1));
      ex_mem_read      = 1'($urandom_range(0, 1));
      mem_load_regfile = 1'($urandom_range(0, 1));
      wb_load_regfile  = 1'($urandom_range(0, 1));
      br_taken  = ($urandom_range(0, 7) == 0);
      imem_req  = ($urandom_range(0, 2) == 0);
      dmem_req  = ($urandom_range(0, 2) == 0);
      imem_resp = ($urandom_range(0, 2) == 0);
      dmem_resp = ($urandom_range(0, 2) == 0);
      perf_clr  = ($urandom_range(0, 31) == 0);
   endtask

   // Inputs are already applied; record the expectation and advance one clock.
   task automatic step();
      q.push_back(m_expect());
      @(posedge clk);
      m_edge();
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("enables", {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load}, e.en);
            chk("flushes", {if_id_flush, id_ex_flush}, e.fl);
            chk("fwd1_sel", fwd1_sel, e.f1);
            chk("fwd2_sel", fwd2_sel, e.f2);
            chk("stall_count", stall_count, e.sc);
            chk("bubble_count", bubble_count, e.bc);
            chk("flush_count", flush_count, e.fc);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin : driver
      idle_inputs();
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("reset_pc_load", pc_load, 0);
      chk("reset_mem_wb_load", mem_wb_load, 0);
      chk("reset_stall_count", stall_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Load-use on rs1, then the same with ex_rd = 0.
      ex_mem_read = 1; ex_load_regfile = 1; ex_rd = 5; id_rs1_addr = 5; id_uses_rs1 = 1;
      step();
      chk("load_use_bubble_count", bubble_count, 1);
      ex_rd = 0; id_rs1_addr = 0;
      step();
      idle_inputs();

      // Forwarding precedence.
      ex_rs1_addr = 3; mem_rd = 3; wb_rd = 3; mem_load_regfile = 1; wb_load_regfile = 1;
      step();
      mem_load_regfile = 0;
      step();
      ex_rs1_addr = 0;
      step();
      idle_inputs();

      // Split responses: imem at cycle 2, dmem at cycle 5.
      perf_clr = 1; step(); perf_clr = 0;
      imem_req = 1; dmem_req = 1;
      for (int c = 0; c <= 5; c++) begin
         imem_resp = (c == 2);
         dmem_resp = (c == 5);
         step();
      end
      chk("split_stall_count", stall_count, 5);
      idle_inputs();

      // Redirect with a simultaneous load-use hazard.
      br_taken = 1; ex_mem_read = 1; ex_load_regfile = 1; ex_rd = 7; id_rs2_addr = 7; id_uses_rs2 = 1;
      step();
      idle_inputs();

      // Redirect held across a 3-cycle data stall.
      br_taken = 1; dmem_req = 1;
      for (int c = 0; c < 4; c++) begin
         dmem_resp = (c == 3);
         step();
      end
      idle_inputs();

      // Stall counter saturation, then clear.
      dmem_req = 1;
      for (int c = 0; c < CMAX + 4; c++) step();
      chk("stall_saturated", stall_count, CMAX);
      dmem_req = 0; perf_clr = 1;
      step();
      chk("perf_clr_stall", stall_count, 0);
      idle_inputs();

      // Reset in mid-WAIT with an imem flag latched; the flag must not survive.
      imem_req = 1; dmem_req = 1;
      step();
      imem_resp = 1;
      step();
      imem_resp = 0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midwait_reset_pc_load", pc_load, 0);
      chk("midwait_reset_stall_count", stall_count, 0);
      m_reset();
      rst_n = 1'b1;
      dmem_req = 0;
      step();
      step();
      idle_inputs();

      for (int c = 0; c < 2000; c++) begin
         rand_inputs();
         step();
      end

      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
